accumulator_feeder: RTL and testbench
=====================================

Name: accumulator_feeder

Overview:
Upstream stage for the N-bit accumulator. It buffers incoming samples in a small FIFO and drives the accumulator's `in` port with one sample per cycle.
- The accumulator has no enable and adds `in` on every clock edge, so this block drives exactly 0 on any cycle with no sample to present. Idle cycles are therefore no-ops for the sum.
- It counts presented samples into frames and flags the last sample of each frame, so a downstream capture stage knows when the accumulator holds a complete frame sum.

Parameters:
- N, 16, sample width; equals the accumulator's N.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- FRAME_LEN, 8, samples per frame; minimum 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N  upstream sample.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- hold  input  1  downstream pause; while high, no sample is presented.
- acc_in  output  N  drives the accumulator's `in` port; registered.
- acc_valid  output  1  acc_in carries a real sample; registered.
- frame_done  output  1  acc_in carries the last sample of a frame; registered.
- fill  output  $clog2(DEPTH)+1  current FIFO occupancy; registered.

Behaviour:
- Reset (async, while reset high):
  - FIFO emptied; all buffered data discarded.
  - acc_in=0, acc_valid=0, frame_done=0, fill=0, frame position=0.
  - in_ready=0 while reset is high.
  - Reset asserted mid-frame discards the partial frame; the frame position restarts at 0.
- in_ready = !reset && fill<DEPTH. It depends only on registered fill, so there is no combinational path from hold or in_valid.
- Push: at a rising edge where in_valid && in_ready, in_data is written at the FIFO tail and fill increments.
- Pop: at a rising edge where fill>0 && !hold:
  - the head is loaded into acc_in, acc_valid<=1, and fill decrements.
- No pop: at a rising edge where fill==0 or hold==1:
  - acc_in<=0, acc_valid<=0, frame_done<=0.
- Pop and push on the same edge: fill is unchanged. Pop reads the pre-push head.
- A push into an empty FIFO is not bypassed.
  - Sample accepted at edge k is popped at edge k+1 at the earliest.
  - acc_in shows it during the cycle after edge k+1.
  - The accumulator includes it in `out` after edge k+2.
- Full FIFO: in_ready=0 even if a pop occurs that same edge (no ready pass-through). in_valid while full is ignored.
- Frame counter (range 0..FRAME_LEN-1) advances only on pops and wraps to 0 after FRAME_LEN-1.
  - frame_done<=1 on the pop where the counter equals FRAME_LEN-1; otherwise frame_done<=0.
  - frame_done is a one-cycle pulse aligned with acc_in.
  - The accumulator `out` holds the frame sum starting one cycle after frame_done.
  - FRAME_LEN=1: every valid sample asserts frame_done.
- hold affects only popping; pushes continue while hold is high.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by fill, not by the pointers.
- acc_in is never X after reset. Memory contents are not reset, but acc_in is only loaded from memory when fill>0.

Decomposition:
- Package accumulator_pkg:
  - default width constant ACC_N=16;
  - function for the fill width, $clog2(DEPTH)+1.
- Sub-module feeder_fifo (N, DEPTH):
  - synchronous FIFO with push/pop/fill and async reset;
  - reads are first-word-fall-through, so head data is visible combinationally.
- accumulator_feeder itself holds the output registers, the frame counter and the ready logic.

Test Plan:
- Reset asserted 40ns, in_valid=0 -> acc_in=0, acc_valid=0, frame_done=0, fill=0, in_ready=0 during reset and 1 after release.
- Push 5 at edge k, hold=0 -> acc_in=5 with acc_valid=1 for exactly one cycle after edge k+1, then 0. The accumulator `out` reads 5 after edge k+2.
- hold=1, push 1..9 back-to-back, DEPTH=8:
  - fill reaches 8, in_ready=0, and the 9th sample is rejected.
  - On release of hold, acc_in shows 1..8 in order over 8 cycles, then 0.
- FRAME_LEN=8, stream 1,1,3,49,127,7,34,2 -> frame_done high only with acc_in=2. The accumulator `out`=224 one cycle later.
- Full FIFO with simultaneous pop -> fill stays 8 and in_ready stays 0 that cycle. The next cycle fill=7 and in_ready=1.
- Reset after 3 samples of a frame, then stream 8 new samples -> frame_done on the 8th new sample, not the 5th.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared constants and helpers for the accumulator front-end blocks.
package accumulator_pkg;

    localparam int ACC_N = 16;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy, not pointer comparison,
// distinguishes full from empty.
module feeder_fifo
    import accumulator_pkg::*;
#(
    parameter int N     = ACC_N,
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [N-1:0]                  push_data,
    input  logic                          pop,
    output logic [N-1:0]                  head,
    output logic [fill_width(DEPTH)-1:0]  fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = fill_width(DEPTH);

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (fill < FILL_W'(DEPTH));
    assign do_pop  = pop && (fill != '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; a slot is only read after it has been written,
    // so resetting it would add reset fan-out for no behavioural benefit.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // a simultaneous push and pop therefore leaves fill unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/accumulator_feeder.sv
// Feeds one buffered sample per cycle into an always-adding accumulator,
// driving zero when idle and flagging the last sample of each frame.
module accumulator_feeder
    import accumulator_pkg::*;
#(
    parameter int N         = ACC_N,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N-1:0]                  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          hold,
    output logic [N-1:0]                  acc_in,
    output logic                          acc_valid,
    output logic                          frame_done,
    output logic [fill_width(DEPTH)-1:0]  fill
);

    localparam int FILL_W = fill_width(DEPTH);
    localparam int POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [N-1:0]     head;
    logic             push;
    logic             pop;
    logic             last;
    logic [POS_W-1:0] frame_pos;

    // Ready looks only at registered occupancy: no path from hold or in_valid.
    assign in_ready = !reset && (fill < FILL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (fill != '0) && !hold;
    assign last     = (frame_pos == POS_W'(FRAME_LEN - 1));

    feeder_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .fill      (fill)
    );

    // Idle cycles drive zero so the accumulator's unconditional add is a no-op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_in     <= '0;
            acc_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_pos  <= '0;
        end else if (pop) begin
            acc_in     <= head;
            acc_valid  <= 1'b1;
            frame_done <= last;
            frame_pos  <= last ? '0 : frame_pos + POS_W'(1);
        end else begin
            acc_in     <= '0;
            acc_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accumulator_feeder.sv
// Self-checking bench: vector table, hand-written frame/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_accumulator_feeder;

    localparam int N         = 16;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 8;
    localparam int FILL_W    = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              hold = 1'b0;
    logic [N-1:0]      acc_in;
    logic              acc_valid;
    logic              frame_done;
    logic [FILL_W-1:0] fill;

    accumulator_feeder #(
        .N         (N),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hold       (hold),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .frame_done (frame_done),
        .fill       (fill)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Downstream accumulator: adds whatever acc_in shows on every edge.
    int acc_sum = 0;

    // Reference model: a plain queue plus a frame position.
    logic [N-1:0] mq [$];
    int           mpos = 0;
    logic [N-1:0] m_acc = '0;
    logic         m_valid = 1'b0;
    logic         m_fd = 1'b0;

    typedef struct {
        logic         rst;
        logic         valid;
        logic [N-1:0] data;
        logic         hold;
        logic [N-1:0] acc_in;
        logic         acc_valid;
        logic         fd;
        int           fill;
        logic         ready;
        int           sum;
    } vec_t;

    vec_t         tbl [$];
    logic [N-1:0] fs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_edge();
        int sz;
        sz = mq.size();
        if (sz > 0 && !hold) begin
            m_acc   = mq.pop_front();
            m_valid = 1'b1;
            m_fd    = (mpos == FRAME_LEN - 1);
            mpos    = (mpos + 1) % FRAME_LEN;
        end else begin
            m_acc   = '0;
            m_valid = 1'b0;
            m_fd    = 1'b0;
        end
        if (in_valid && sz < DEPTH) begin
            mq.push_back(in_data);
        end
    endtask

    task automatic step();
        logic [N-1:0] pre;
        pre = acc_in;
        @(posedge clock);
        model_edge();
        acc_sum = acc_sum + 32'(pre);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        in_data  = '0;
        mq.delete();
        mpos     = 0;
        m_acc    = '0;
        m_valid  = 1'b0;
        m_fd     = 1'b0;
        acc_sum  = 0;
        #1;
        check("rst_acc_in", 32'(acc_in), 0);
        check("rst_acc_valid", 32'(acc_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_fill", 32'(fill), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        #40;
        check("rst_in_ready_held", 32'(in_ready), 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_fill", 32'(fill), 0);
    endtask

    task automatic add_vec(input logic r, input logic v, input int d, input logic h,
                           input int a, input logic av, input logic fd, input int f,
                           input logic rdy, input int s);
        vec_t x;
        x.rst = r; x.valid = v; x.data = N'(d); x.hold = h;
        x.acc_in = N'(a); x.acc_valid = av; x.fd = fd; x.fill = f; x.ready = rdy; x.sum = s;
        tbl.push_back(x);
    endtask

    task automatic stream8(input int exp_sum);
        for (int j = 0; j <= 8; j++) begin
            in_valid = (j < 8);
            in_data  = (j < 8) ? fs[j % 8] : '0;
            hold     = 1'b0;
            step();
            check("stream_acc_in", 32'(acc_in), (j > 0) ? 32'(fs[(j + 7) % 8]) : 0);
            check("stream_acc_valid", 32'(acc_valid), (j > 0) ? 1 : 0);
            check("stream_frame_done", 32'(frame_done), (j == 8) ? 1 : 0);
        end
        in_valid = 1'b0;
        step();
        check("stream_idle_acc_in", 32'(acc_in), 0);
        check("stream_idle_frame_done", 32'(frame_done), 0);
        check("stream_frame_sum", 32'(acc_sum), 32'(exp_sum));
    endtask

    initial begin
        // Single sample: accepted at edge k, shown after edge k+1, summed after k+2.
        add_vec(1, 1, 5, 0, 0, 0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        // Hold while pushing 1..9: fills to DEPTH and rejects the ninth.
        for (int i = 1; i <= 8; i++) begin
            add_vec((i == 1), 1, i, 1, 0, 0, 0, i, (i < 8), 0);
        end
        add_vec(0, 1, 9, 1, 0, 0, 0, 8, 0, 0);
        // Release with a simultaneous offer while full: pop happens, offer is ignored.
        add_vec(0, 1, 99, 0, 1, 1, 0, 7, 1, 0);
        for (int j = 2; j <= 8; j++) begin
            add_vec(0, 0, 0, 0, j, 1, (j == 8), 8 - j, 1, (j - 1) * j / 2);
        end
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 36);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            in_valid = tbl[i].valid;
            in_data  = tbl[i].data;
            hold     = tbl[i].hold;
            step();
            check("tbl_acc_in", 32'(acc_in), 32'(tbl[i].acc_in));
            check("tbl_acc_valid", 32'(acc_valid), 32'(tbl[i].acc_valid));
            check("tbl_frame_done", 32'(frame_done), 32'(tbl[i].fd));
            check("tbl_fill", 32'(fill), 32'(tbl[i].fill));
            check("tbl_in_ready", 32'(in_ready), 32'(tbl[i].ready));
            check("tbl_acc_sum", 32'(acc_sum), 32'(tbl[i].sum));
        end

        // Full frame: frame_done only alongside the last sample, sum 224.
        do_reset();
        fs = '{16'd1, 16'd1, 16'd3, 16'd49, 16'd127, 16'd7, 16'd34, 16'd2};
        stream8(224);

        // Partial frame discarded by reset; the next frame counts from zero.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            in_valid = (j < 3);
            in_data  = N'(100 + j);
            step();
            check("partial_frame_done", 32'(frame_done), 0);
        end
        in_valid = 1'b0;
        do_reset();
        fs = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17};
        stream8(108);

        // Randomized traffic against the queue model; heavier hold early to reach full.
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            hold     = ($urandom_range(0, 99) < ((c < 300) ? 60 : 20));
            in_data  = N'($urandom);
            step();
            check("rnd_acc_in", 32'(acc_in), 32'(m_acc));
            check("rnd_acc_valid", 32'(acc_valid), 32'(m_valid));
            check("rnd_frame_done", 32'(frame_done), 32'(m_fd));
            check("rnd_fill", 32'(fill), 32'(mq.size()));
            check("rnd_in_ready", 32'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
